// File: rtl/multicycle_control.sv
// multicycle_control: sequencer for the multi-cycle MIPS datapath.
// Drives mux selects, enables and ALU op; stalls on memory ready.
module multicycle_control #(
  parameter int WAIT_LIMIT = 15,
  parameter int COUNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_i,
  input  logic [5:0]         opcode_i,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic [1:0]         pc_src_o,
  output logic               ir_write_o,
  output logic               iord_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               reg_write_o,
  output logic [1:0]         reg_dst_o,
  output logic [1:0]         wb_src_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [3:0]         alu_op_o,
  output logic [3:0]         state_o,
  output logic [COUNT_W-1:0] instr_count_o,
  output logic               illegal_o,
  output logic               bus_error_o
);

  localparam int WW =
    (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WW-1:0] LIM_M1 =
    WW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
  localparam bit HAS_LIM = (WAIT_LIMIT > 0);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JAL      = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  state_e             state_q, state_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;

  state_e      dec_next;
  logic [3:0]  imm_op;
  logic        timeout;
  logic        retire;

  logic        pc_write_c;
  logic [1:0]  pc_src_c;
  logic        ir_write_c;
  logic        iord_c;
  logic        mem_read_c;
  logic        mem_write_c;
  logic        reg_write_c;
  logic [1:0]  reg_dst_c;
  logic [1:0]  wb_src_c;
  logic        alu_src_a_c;
  logic [1:0]  alu_src_b_c;
  logic [3:0]  alu_op_c;

  always_comb begin
    dec_next = S_HALT;
    imm_op   = 4'b0000;
    case (opcode_i)
      OP_R:    dec_next = S_EXEC_R;
      OP_ADDI: begin
        dec_next = S_EXEC_I;
        imm_op   = 4'b0000;
      end
      OP_ORI: begin
        dec_next = S_EXEC_I;
        imm_op   = 4'b0001;
      end
      OP_LUI: begin
        dec_next = S_EXEC_I;
        imm_op   = 4'b0010;
      end
      OP_ANDI: begin
        dec_next = S_EXEC_I;
        imm_op   = 4'b0011;
      end
      OP_LW:   dec_next = S_MEM_ADDR;
      OP_SW:   dec_next = S_MEM_ADDR;
      OP_BEQ:  dec_next = S_BRANCH;
      OP_BNE:  dec_next = S_BRANCH;
      OP_J:    dec_next = S_JUMP;
      OP_JAL:  dec_next = S_JAL;
      default: dec_next = S_HALT;
    endcase
  end

  // Last allowed not-ready cycle; a ready on it still completes.
  assign timeout = HAS_LIM && (wait_q == LIM_M1);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    count_d     = count_q;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    retire      = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 2'b00;
    ir_write_c  = 1'b0;
    iord_c      = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    reg_dst_c   = 2'b00;
    wb_src_c    = 2'b00;
    alu_src_a_c = 1'b0;
    alu_src_b_c = 2'b00;
    alu_op_c    = 4'b0000;

    unique case (state_q)
      S_FETCH: begin
        if (run_i) begin
          mem_read_c  = 1'b1;
          alu_src_b_c = 2'b01;
          if (mem_ready_i) begin
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
            state_d    = S_DECODE;
          end else if (timeout) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else begin
          wait_d = '0;
        end
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        state_d     = dec_next;
        if (dec_next == S_HALT) illegal_d = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 4'b1111;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_op_c    = imm_op;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = (opcode_i == OP_R) ? 2'b01 : 2'b00;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        if (opcode_i == OP_SW) begin
          alu_op_c = 4'b0101;
          state_d  = S_MEM_WR;
        end else begin
          alu_op_c = 4'b0100;
          state_d  = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        iord_c     = 1'b1;
        mem_read_c = 1'b1;
        if (mem_ready_i) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_MEM_WR: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready_i) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_MEM_WB: begin
        reg_write_c = 1'b1;
        wb_src_c    = 2'b01;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        pc_src_c    = 2'b01;
        if (opcode_i == OP_BNE) begin
          alu_op_c   = 4'b0111;
          pc_write_c = ~zero_i;
        end else begin
          alu_op_c   = 4'b0110;
          pc_write_c = zero_i;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src_c   = 2'b10;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        pc_write_c  = 1'b1;
        pc_src_c    = 2'b10;
        reg_write_c = 1'b1;
        reg_dst_c   = 2'b10;
        wb_src_c    = 2'b10;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    if (state_d != state_q &&
        (state_d == S_FETCH ||
         state_d == S_MEM_RD ||
         state_d == S_MEM_WR)) begin
      wait_d = '0;
    end
    if (retire) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Datapath controls are held quiet for the whole reset window.
  assign pc_write_o    = reset & pc_write_c;
  assign pc_src_o      = reset ? pc_src_c : 2'b00;
  assign ir_write_o    = reset & ir_write_c;
  assign iord_o        = reset & iord_c;
  assign mem_read_o    = reset & mem_read_c;
  assign mem_write_o   = reset & mem_write_c;
  assign reg_write_o   = reset & reg_write_c;
  assign reg_dst_o     = reset ? reg_dst_c : 2'b00;
  assign wb_src_o      = reset ? wb_src_c : 2'b00;
  assign alu_src_a_o   = reset & alu_src_a_c;
  assign alu_src_b_o   = reset ? alu_src_b_c : 2'b00;
  assign alu_op_o      = reset ? alu_op_c : 4'b0000;
  assign state_o       = state_q;
  assign instr_count_o = count_q;
  assign illegal_o     = illegal_q;
  assign bus_error_o   = bus_err_q;

endmodule
